// File: rtl/corevx_lsu_pkg.sv
// corevx_lsu_pkg: shared encodings for the load/store sequencer.
//   - LSU_OP_*        : execute -> LSU operation codes
//   - EXC_*           : RISC-V exception cause values (mirror corevx_exception.svh)
//   - CACHE_CMD_*     : LSU -> cache commands (mirror corevx_cache.svh)
//   - CACHE_RESPONSE_*: cache -> LSU response codes (mirror corevx_cache.svh)
//   - lsu_state_e     : sequencer FSM states
package corevx_lsu_pkg;

    localparam logic [1:0] LSU_OP_NONE  = 2'd0;
    localparam logic [1:0] LSU_OP_LOAD  = 2'd1;
    localparam logic [1:0] LSU_OP_STORE = 2'd2;
    localparam logic [1:0] LSU_OP_FENCE = 2'd3;

    localparam logic [31:0] EXC_ILLEGAL_INSTR      = 32'd2;
    localparam logic [31:0] EXC_LOAD_MISALIGNED    = 32'd4;
    localparam logic [31:0] EXC_LOAD_ACCESS_FAULT  = 32'd5;
    localparam logic [31:0] EXC_STORE_MISALIGNED   = 32'd6;
    localparam logic [31:0] EXC_STORE_ACCESS_FAULT = 32'd7;
    localparam logic [31:0] EXC_LOAD_PAGE_FAULT    = 32'd13;
    localparam logic [31:0] EXC_STORE_PAGE_FAULT   = 32'd15;

    localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
    localparam logic [3:0] CACHE_CMD_LOAD      = 4'd1;
    localparam logic [3:0] CACHE_CMD_STORE     = 4'd2;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd3;

    localparam logic [3:0] CACHE_RESPONSE_NONE        = 4'd0;
    localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } lsu_state_e;

    // Cache command issued for a legal request.
    function automatic logic [3:0] op_to_cmd(input logic [1:0] op);
        case (op)
            LSU_OP_LOAD:  return CACHE_CMD_LOAD;
            LSU_OP_STORE: return CACHE_CMD_STORE;
            LSU_OP_FENCE: return CACHE_CMD_FLUSH_ALL;
            default:      return CACHE_CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/corevx_lsu_align.sv
// corevx_lsu_align: combinational legality/alignment check of a request.
//   op, funct3, addr[1:0] in; illegal (bad funct3), misaligned (natural
//   alignment violated) and the matching exception cause out.
module corevx_lsu_align
    import corevx_lsu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic        illegal,
    output logic        misaligned,
    output logic [31:0] cause
);

    logic is_load;
    logic is_store;

    assign is_load  = (op == LSU_OP_LOAD);
    assign is_store = (op == LSU_OP_STORE);

    always_comb begin
        illegal = 1'b0;
        if (is_load)
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        else if (is_store)
            illegal = (funct3 >= 3'd3);
    end

    // funct3[1:0] is the access size for both signed and unsigned loads.
    assign misaligned = (is_load || is_store) &&
                        (((funct3[1:0] == 2'd1) && addr[0]) ||
                         ((funct3[1:0] == 2'd2) && (addr != 2'b00)));

    always_comb begin
        if (illegal)
            cause = EXC_ILLEGAL_INSTR;
        else if (is_load)
            cause = EXC_LOAD_MISALIGNED;
        else
            cause = EXC_STORE_MISALIGNED;
    end

endmodule

// File: rtl/corevx_lsu.sv
// corevx_lsu: load/store sequencer between execute and the data cache.
//   Execute side : e2l_valid/op/funct3/address/store_data in;
//                  l2e_done pulse with load_data/exc/exc_cause, l2e_busy out.
//   Cache side   : c_cmd/address/load_type/store_type/store_data out;
//                  c_reset_done, c_response, c_load_data in.
//   Parameters   : WAIT_CYCLES (watchdog bound), CHECK_ALIGN (local trap of
//                  misaligned accesses).
module corevx_lsu
    import corevx_lsu_pkg::*;
#(
    parameter int WAIT_CYCLES = 64,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e2l_valid,
    input  logic [1:0]  e2l_op,
    input  logic [2:0]  e2l_funct3,
    input  logic [31:0] e2l_address,
    input  logic [31:0] e2l_store_data,
    output logic        l2e_done,
    output logic [31:0] l2e_load_data,
    output logic        l2e_exc,
    output logic [31:0] l2e_exc_cause,
    output logic        l2e_busy,
    input  logic        c_reset_done,
    output logic [3:0]  c_cmd,
    output logic [31:0] c_address,
    output logic [2:0]  c_load_type,
    output logic [1:0]  c_store_type,
    output logic [31:0] c_store_data,
    input  logic [3:0]  c_response,
    input  logic [31:0] c_load_data
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       f3_q, f3_d;

    logic        al_illegal;
    logic        al_misaligned;
    logic [31:0] al_cause;
    logic        load_q;

    corevx_lsu_align u_align (
        .op         (e2l_op),
        .funct3     (e2l_funct3),
        .addr       (e2l_address[1:0]),
        .illegal    (al_illegal),
        .misaligned (al_misaligned),
        .cause      (al_cause)
    );

    // Address/data paths are pass-through; execute holds them until done.
    assign c_address    = e2l_address;
    assign c_store_data = e2l_store_data;
    assign c_load_type  = e2l_funct3;
    assign c_store_type = e2l_funct3[1:0];
    assign l2e_busy     = (state_q != ST_IDLE);

    // Fences report with store causes, so only a load selects load causes.
    assign load_q = (op_q == LSU_OP_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= LSU_OP_NONE;
            f3_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        f3_d          = f3_q;
        c_cmd         = CACHE_CMD_NONE;
        l2e_done      = 1'b0;
        l2e_exc       = 1'b0;
        l2e_exc_cause = 32'd0;
        l2e_load_data = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (e2l_valid && c_reset_done) begin
                    if (e2l_op == LSU_OP_NONE) begin
                        l2e_done = 1'b1;
                    end else if (al_illegal || ((CHECK_ALIGN != 0) && al_misaligned)) begin
                        l2e_done      = 1'b1;
                        l2e_exc       = 1'b1;
                        l2e_exc_cause = al_cause;
                    end else begin
                        c_cmd   = op_to_cmd(e2l_op);
                        cnt_d   = '0;
                        op_d    = e2l_op;
                        f3_d    = e2l_funct3;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != CNT_MAX)
                    cnt_d = cnt_q + 1'b1;
                // A response is checked first so it wins over a same-cycle expiry.
                if (c_response != CACHE_RESPONSE_NONE) begin
                    l2e_done = 1'b1;
                    state_d  = ST_IDLE;
                    case (c_response)
                        CACHE_RESPONSE_DONE: begin
                            if (load_q)
                                l2e_load_data = c_load_data;
                        end
                        CACHE_RESPONSE_MISSALIGNED: begin
                            l2e_exc       = 1'b1;
                            l2e_exc_cause = load_q ? EXC_LOAD_MISALIGNED : EXC_STORE_MISALIGNED;
                        end
                        CACHE_RESPONSE_PAGEFAULT: begin
                            l2e_exc       = 1'b1;
                            l2e_exc_cause = load_q ? EXC_LOAD_PAGE_FAULT : EXC_STORE_PAGE_FAULT;
                        end
                        default: begin
                            // ACCESSFAULT, and any unknown code reported the same way.
                            l2e_exc       = 1'b1;
                            l2e_exc_cause = load_q ? EXC_LOAD_ACCESS_FAULT : EXC_STORE_ACCESS_FAULT;
                        end
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog: complete with a fault, then swallow the late response.
                    l2e_done      = 1'b1;
                    l2e_exc       = 1'b1;
                    l2e_exc_cause = load_q ? EXC_LOAD_ACCESS_FAULT : EXC_STORE_ACCESS_FAULT;
                    state_d       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (c_response != CACHE_RESPONSE_NONE)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Execute must keep the in-flight request stable while it is waiting.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_WAIT) && e2l_valid)
            assert ((e2l_op == op_q) && (e2l_funct3 == f3_q));
    end

endmodule

// File: tb/tb_corevx_lsu.sv
// tb_corevx_lsu: directed table, randomized model comparison and hand
// sequences for corevx_lsu. Instance 0: WAIT_CYCLES=6, CHECK_ALIGN=1;
// instance 1: WAIT_CYCLES=4, CHECK_ALIGN=0. 'sel' picks the active one.
module tb_corevx_lsu;
    import corevx_lsu_pkg::*;

    localparam int WA = 6;
    localparam int WB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        e2l_valid;
    logic [1:0]  e2l_op;
    logic [2:0]  e2l_funct3;
    logic [31:0] e2l_address;
    logic [31:0] e2l_store_data;
    logic        c_reset_done;
    logic [3:0]  c_response;
    logic [31:0] c_load_data;

    logic [1:0]       o_done, o_exc, o_busy;
    logic [1:0][31:0] o_ldata, o_cause, o_addr, o_sdata;
    logic [1:0][3:0]  o_cmd;
    logic [1:0][2:0]  o_ltype;
    logic [1:0][1:0]  o_stype;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        corevx_lsu #(.WAIT_CYCLES(g == 0 ? WA : WB), .CHECK_ALIGN(g == 0 ? 1 : 0)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .e2l_valid      (e2l_valid && (sel == 1'(g))),
            .e2l_op         (e2l_op),
            .e2l_funct3     (e2l_funct3),
            .e2l_address    (e2l_address),
            .e2l_store_data (e2l_store_data),
            .l2e_done       (o_done[g]),
            .l2e_load_data  (o_ldata[g]),
            .l2e_exc        (o_exc[g]),
            .l2e_exc_cause  (o_cause[g]),
            .l2e_busy       (o_busy[g]),
            .c_reset_done   (c_reset_done),
            .c_cmd          (o_cmd[g]),
            .c_address      (o_addr[g]),
            .c_load_type    (o_ltype[g]),
            .c_store_type   (o_stype[g]),
            .c_store_data   (o_sdata[g]),
            .c_response     (c_response),
            .c_load_data    (c_load_data)
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          done_cyc;
        int          end_cyc;
        bit          exc;
        logic [31:0] cause;
        bit          chk_data;
        logic [31:0] data;
        logic [3:0]  cmd;
    } exp_t;

    typedef struct {
        bit          s;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          lat;
        logic [3:0]  resp;
        logic [31:0] rdata;
        int          e_done;
        bit          e_exc;
        logic [31:0] e_cause;
        logic [3:0]  e_cmd;
    } vec_t;

    task automatic do_reset();
        rst_n = 1'b0;
        e2l_valid = 1'b0; e2l_op = LSU_OP_NONE; e2l_funct3 = 3'd0;
        e2l_address = 32'd0; e2l_store_data = 32'd0;
        c_response = CACHE_RESPONSE_NONE; c_load_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drive one request starting at cycle 0 (right after a clock edge) and check every
    // cycle until the completion and any watchdog drain are over.
    task automatic run_txn(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int lat, input logic [3:0] resp,
                           input logic [31:0] rd, input exp_t e, input string tag);
        e2l_valid = 1'b1; e2l_op = op; e2l_funct3 = f3; e2l_address = a; e2l_store_data = sd;
        for (int c = 0; c <= e.end_cyc; c++) begin
            c_response  = (e.cmd != CACHE_CMD_NONE && c == lat) ? resp : CACHE_RESPONSE_NONE;
            c_load_data = (c == lat) ? rd : $urandom;
            @(negedge clk);
            chk({tag, ".done"}, 32'(o_done[sel]), 32'(c == e.done_cyc));
            chk({tag, ".exc"}, 32'(o_exc[sel]), 32'(c == e.done_cyc && e.exc));
            chk({tag, ".cmd"}, 32'(o_cmd[sel]), 32'(c == 0 ? e.cmd : CACHE_CMD_NONE));
            chk({tag, ".busy"}, 32'(o_busy[sel]), 32'(e.cmd != CACHE_CMD_NONE && c > 0));
            if (c == e.done_cyc && e.exc)
                chk({tag, ".cause"}, o_cause[sel], e.cause);
            if (c == e.done_cyc && e.chk_data)
                chk({tag, ".ldata"}, o_ldata[sel], e.data);
            if (c == 0) begin
                chk({tag, ".c_addr"}, o_addr[sel], a);
                chk({tag, ".c_sdata"}, o_sdata[sel], sd);
                chk({tag, ".c_types"}, 32'({o_ltype[sel], o_stype[sel]}), 32'({f3, f3[1:0]}));
            end
            @(posedge clk); #1;
            if (c == e.done_cyc) e2l_valid = 1'b0;
        end
        c_response = CACHE_RESPONSE_NONE;
    endtask

    // Reference model: outcome computed directly from the architectural rules.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                                   input int lat, input logic [3:0] resp, input logic [31:0] rd,
                                   input int w, input bit align);
        exp_t e;
        bit ld, st, bad, mis;
        int size;
        ld = (op == LSU_OP_LOAD);
        st = (op == LSU_OP_STORE);
        size = int'(f3) % 4;
        bad = ld ? (f3 == 3 || f3 >= 6) : (st ? (f3 >= 3) : 1'b0);
        mis = (ld || st) && ((size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0));
        e = '{done_cyc: 0, end_cyc: 0, exc: 1'b0, cause: 32'd0, chk_data: 1'b0, data: 32'd0,
              cmd: CACHE_CMD_NONE};
        if (op == LSU_OP_NONE) return e;
        if (bad) begin e.exc = 1; e.cause = 2; return e; end
        if (mis && align) begin e.exc = 1; e.cause = ld ? 4 : 6; return e; end
        e.cmd = ld ? CACHE_CMD_LOAD : (st ? CACHE_CMD_STORE : CACHE_CMD_FLUSH_ALL);
        e.end_cyc = lat;
        if (lat > w) begin
            e.done_cyc = w; e.exc = 1; e.cause = ld ? 5 : 7;
        end else begin
            e.done_cyc = lat;
            case (resp)
                CACHE_RESPONSE_DONE: begin e.chk_data = ld; e.data = rd; end
                CACHE_RESPONSE_MISSALIGNED: begin e.exc = 1; e.cause = ld ? 4 : 6; end
                CACHE_RESPONSE_ACCESSFAULT: begin e.exc = 1; e.cause = ld ? 5 : 7; end
                default: begin e.exc = 1; e.cause = ld ? 13 : 15; end
            endcase
        end
        return e;
    endfunction

    vec_t vecs[$];

    initial begin
        exp_t e;
        sel = 1'b0;
        c_reset_done = 1'b1;
        do_reset();
        rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.done", 32'(o_done[0]), 0);
        chk("rst.exc", 32'(o_exc[0]), 0);
        chk("rst.cause", o_cause[0], 0);
        chk("rst.ldata", o_ldata[0], 0);
        chk("rst.busy", 32'(o_busy[0]), 0);
        chk("rst.cmd", 32'(o_cmd[0]), 32'(CACHE_CMD_NONE));
        chk("rst.addr", o_addr[0], 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed table: {sel, op, f3, addr, lat, resp, rdata} -> {done cycle, exc, cause, cmd}
        vecs.push_back('{0, LSU_OP_LOAD,  3'd2, 32'h1000, 3, CACHE_RESPONSE_DONE,        32'hDEADBEEF, 3, 0, 0,  CACHE_CMD_LOAD});
        vecs.push_back('{0, LSU_OP_STORE, 3'd1, 32'h1001, 0, CACHE_RESPONSE_NONE,        32'h0,        0, 1, 6,  CACHE_CMD_NONE});
        vecs.push_back('{1, LSU_OP_STORE, 3'd1, 32'h1001, 2, CACHE_RESPONSE_MISSALIGNED, 32'h0,        2, 1, 6,  CACHE_CMD_STORE});
        vecs.push_back('{0, LSU_OP_LOAD,  3'd0, 32'h2000, 2, CACHE_RESPONSE_PAGEFAULT,   32'h0,        2, 1, 13, CACHE_CMD_LOAD});
        vecs.push_back('{0, LSU_OP_STORE, 3'd2, 32'h3000, 1, CACHE_RESPONSE_ACCESSFAULT, 32'h0,        1, 1, 7,  CACHE_CMD_STORE});
        vecs.push_back('{0, LSU_OP_FENCE, 3'd0, 32'h0,    4, CACHE_RESPONSE_PAGEFAULT,   32'h0,        4, 1, 15, CACHE_CMD_FLUSH_ALL});
        vecs.push_back('{0, LSU_OP_LOAD,  3'd3, 32'h10,   0, CACHE_RESPONSE_NONE,        32'h0,        0, 1, 2,  CACHE_CMD_NONE});
        vecs.push_back('{0, LSU_OP_STORE, 3'd4, 32'h10,   0, CACHE_RESPONSE_NONE,        32'h0,        0, 1, 2,  CACHE_CMD_NONE});
        vecs.push_back('{0, LSU_OP_LOAD,  3'd5, 32'h1003, 0, CACHE_RESPONSE_NONE,        32'h0,        0, 1, 4,  CACHE_CMD_NONE});
        vecs.push_back('{0, LSU_OP_NONE,  3'd0, 32'h0,    0, CACHE_RESPONSE_NONE,        32'h0,        0, 0, 0,  CACHE_CMD_NONE});
        vecs.push_back('{0, LSU_OP_LOAD,  3'd2, 32'h40,   6, CACHE_RESPONSE_DONE,        32'h12345678, 6, 0, 0,  CACHE_CMD_LOAD});
        vecs.push_back('{0, LSU_OP_LOAD,  3'd4, 32'h41,   9, CACHE_RESPONSE_DONE,        32'h0,        6, 1, 5,  CACHE_CMD_LOAD});
        vecs.push_back('{1, LSU_OP_LOAD,  3'd1, 32'h43,   1, CACHE_RESPONSE_DONE,        32'h0000CAFE, 1, 0, 0,  CACHE_CMD_LOAD});
        vecs.push_back('{0, LSU_OP_STORE, 3'd0, 32'h7,    1, CACHE_RESPONSE_DONE,        32'h0,        1, 0, 0,  CACHE_CMD_STORE});
        vecs.push_back('{0, LSU_OP_FENCE, 3'd0, 32'h0,    7, CACHE_RESPONSE_DONE,        32'h0,        6, 1, 7,  CACHE_CMD_FLUSH_ALL});

        foreach (vecs[i]) begin
            do_reset();
            sel = vecs[i].s;
            e.done_cyc = vecs[i].e_done;
            e.end_cyc  = (vecs[i].e_cmd != CACHE_CMD_NONE && vecs[i].lat > vecs[i].e_done) ?
                         vecs[i].lat : vecs[i].e_done;
            e.exc      = vecs[i].e_exc;
            e.cause    = vecs[i].e_cause;
            e.chk_data = (vecs[i].op == LSU_OP_LOAD) && !vecs[i].e_exc;
            e.data     = vecs[i].rdata;
            e.cmd      = vecs[i].e_cmd;
            run_txn(vecs[i].op, vecs[i].f3, vecs[i].addr, $urandom, vecs[i].lat, vecs[i].resp,
                    vecs[i].rdata, e, $sformatf("vec%0d", i));
        end

        // Randomized back-to-back traffic against the model (instance 0)
        do_reset();
        sel = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  op;
            logic [2:0]  f3;
            logic [31:0] a, rd;
            logic [3:0]  resp;
            int          lat;
            op  = 2'($urandom_range(0, 3));
            f3  = 3'($urandom);
            a   = $urandom;
            lat = $urandom_range(1, 9);
            rd  = $urandom;
            case ($urandom_range(0, 5))
                0: resp = CACHE_RESPONSE_MISSALIGNED;
                1: resp = CACHE_RESPONSE_ACCESSFAULT;
                2: resp = CACHE_RESPONSE_PAGEFAULT;
                default: resp = CACHE_RESPONSE_DONE;
            endcase
            e = model(op, f3, a, lat, resp, rd, WA, 1'b1);
            run_txn(op, f3, a, $urandom, lat, resp, rd, e, $sformatf("rnd%0d", i));
        end

        // Watchdog drain on instance 1: new request ignored until the late response
        do_reset();
        sel = 1'b1;
        e2l_valid = 1'b1; e2l_op = LSU_OP_LOAD; e2l_funct3 = 3'd2; e2l_address = 32'h100;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 0) chk("wd.issue", 32'(o_cmd[1]), 32'(CACHE_CMD_LOAD));
            chk("wd.done", 32'(o_done[1]), 32'(c == 4));
            if (c == 4) begin
                chk("wd.exc", 32'(o_exc[1]), 1);
                chk("wd.cause", o_cause[1], 5);
            end
            @(posedge clk); #1;
        end
        e2l_op = LSU_OP_STORE; e2l_address = 32'h200;
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            chk("drain.done", 32'(o_done[1]), 0);
            chk("drain.cmd", 32'(o_cmd[1]), 32'(CACHE_CMD_NONE));
            chk("drain.busy", 32'(o_busy[1]), 1);
            @(posedge clk); #1;
        end
        c_response = CACHE_RESPONSE_DONE;
        @(negedge clk);
        chk("drain.resp_nodone", 32'(o_done[1]), 0);
        @(posedge clk); #1 c_response = CACHE_RESPONSE_NONE;
        @(negedge clk);
        chk("drain.next_busy", 32'(o_busy[1]), 0);
        chk("drain.next_issue", 32'(o_cmd[1]), 32'(CACHE_CMD_STORE));
        @(posedge clk); #1 c_response = CACHE_RESPONSE_DONE;
        @(negedge clk);
        chk("drain.next_done", 32'({o_done[1], o_exc[1]}), 32'b10);
        @(posedge clk); #1 c_response = CACHE_RESPONSE_NONE; e2l_valid = 1'b0;

        // Cache not ready: request held until c_reset_done; response honoured in WAIT anyway
        do_reset();
        sel = 1'b0;
        c_reset_done = 1'b0;
        e2l_valid = 1'b1; e2l_op = LSU_OP_LOAD; e2l_funct3 = 3'd2; e2l_address = 32'h300;
        repeat (3) begin
            @(negedge clk);
            chk("nrdy.cmd", 32'(o_cmd[0]), 32'(CACHE_CMD_NONE));
            chk("nrdy.done_busy", 32'({o_done[0], o_busy[0]}), 0);
            @(posedge clk); #1;
        end
        c_reset_done = 1'b1;
        @(negedge clk);
        chk("nrdy.issue", 32'(o_cmd[0]), 32'(CACHE_CMD_LOAD));
        @(posedge clk); #1;
        c_reset_done = 1'b0; c_response = CACHE_RESPONSE_DONE; c_load_data = 32'h55;
        @(negedge clk);
        chk("nrdy.done", 32'({o_done[0], o_exc[0]}), 32'b10);
        chk("nrdy.ldata", o_ldata[0], 32'h55);
        @(posedge clk); #1;
        c_response = CACHE_RESPONSE_NONE; e2l_valid = 1'b0; c_reset_done = 1'b1;

        // Reset while waiting: back to IDLE, stale response ignored
        do_reset();
        sel = 1'b0;
        e2l_valid = 1'b1; e2l_op = LSU_OP_LOAD; e2l_funct3 = 3'd2; e2l_address = 32'h400;
        @(negedge clk);
        chk("rstw.issue", 32'(o_cmd[0]), 32'(CACHE_CMD_LOAD));
        @(posedge clk); #1;
        rst_n = 1'b0; e2l_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstw.idle", 32'({o_busy[0], o_done[0], o_exc[0]}), 0);
        chk("rstw.cmd", 32'(o_cmd[0]), 32'(CACHE_CMD_NONE));
        chk("rstw.cause", o_cause[0], 0);
        @(posedge clk); #1;
        c_response = CACHE_RESPONSE_DONE; c_load_data = 32'hAA;
        @(negedge clk);
        chk("rstw.stale", 32'({o_done[0], o_busy[0]}), 0);
        chk("rstw.stale_ldata", o_ldata[0], 0);
        @(posedge clk); #1 c_response = CACHE_RESPONSE_NONE;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/corevx_lsu.md
# corevx_lsu

Load/store sequencer between the execute stage and the data cache. Accepts one load, store or fence request at a time and checks alignment before any cache access. Drives the cache command/response handshake, maps cache error responses onto RISC-V exception causes, and bounds every access with a watchdog. It replaces the ad-hoc command-issued flag in execute with an explicit FSM, so execute only waits for a single completion pulse.

## Interface

Parameters:
- WAIT_CYCLES, default 64: maximum cycles in WAIT before watchdog fault; legal range 2..65535.
- CHECK_ALIGN, default 1: 1 = misaligned accesses trap locally; 0 = forwarded to cache, which reports them.

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- e2l_valid, in, 1: request valid; held with stable fields until l2e_done.
- e2l_op, in, 2: LSU_OP_NONE/LOAD/STORE/FENCE.
- e2l_funct3, in, 3: instruction funct3 (size/sign).
- e2l_address, in, 32: effective address.
- e2l_store_data, in, 32: store data.
- l2e_done, out, 1: one-cycle completion pulse.
- l2e_load_data, out, 32: load result, valid with l2e_done on loads.
- l2e_exc, out, 1: completion carries an exception.
- l2e_exc_cause, out, 32: RISC-V cause, valid when l2e_exc.
- l2e_busy, out, 1: FSM not IDLE.
- c_reset_done, in, 1: cache ready after reset.
- c_cmd, out, 4: CACHE_CMD_NONE/LOAD/STORE/FLUSH_ALL.
- c_address, out, 32; c_load_type, out, 3 (= funct3); c_store_type, out, 2 (= funct3[1:0]); c_store_data, out, 32.
- c_response, in, 4: CACHE_RESPONSE_* code.
- c_load_data, in, 32: cache load data.

## Operation

- States: IDLE, WAIT, DRAIN.
- IDLE, e2l_valid && c_reset_done:
  - Op NONE: l2e_done, no exception.
  - Illegal funct3 (load 3/6/7, store ≥3): l2e_done+exc, cause 2.
  - Misaligned with CHECK_ALIGN=1 (half: addr[0]; word: addr[1:0]≠0): l2e_done+exc, cause 4 (load) / 6 (store); no cache command.
  - Otherwise: c_cmd issued this cycle, counter ← 0, → WAIT.
- WAIT: c_cmd = NONE; counter increments each cycle.
  - DONE: l2e_done; load data = c_load_data; → IDLE.
  - MISSALIGNED: cause 4/6. ACCESSFAULT: 5/7. PAGEFAULT: 13/15. l2e_done+exc, → IDLE.
  - FENCE uses store causes on any error.
  - Counter reaches WAIT_CYCLES−1 with no response: l2e_done+exc, access-fault cause (5 or 7), → DRAIN.
- DRAIN: c_cmd = NONE, ignore e2l_valid; any non-NONE response → IDLE. Response payload discarded.
- Counter width $clog2(WAIT_CYCLES+1), saturating; no wrap.
- op and funct3 of the request in flight are registered at issue; cause mapping uses the registered copy.

## Timing

- Reset: state IDLE, counter 0, all outputs 0 (c_cmd = CACHE_CMD_NONE).
- l2e_done, l2e_exc, l2e_exc_cause and l2e_load_data are combinational in the completion cycle. Execute samples them at that clock edge.
- Latency:
  - Local trap: 0 cycles (same cycle as e2l_valid).
  - Cache access: response cycle; minimum 1 cycle after issue.
- Back-to-back: the next request is accepted in the cycle after l2e_done.
- Response arriving in the same cycle as the watchdog expiry: the response wins, no fault, → IDLE.
- c_reset_done low: IDLE holds, no done. In WAIT, responses are still honoured.
- c_address, c_store_data and c_load_type follow the e2l_* inputs combinationally, so execute must hold them stable.
- Reset mid-access: FSM returns to IDLE. A late cache response is ignored in IDLE; the cache is reset by the same rst_n.

## Structure

- Shared package corevx_lsu_pkg:
  - LSU_OP_* encodings.
  - Exception cause constants 2, 4, 5, 6, 7, 13, 15 (shared with corevx_exception.svh).
  - State enum.
- CACHE_CMD_* and CACHE_RESPONSE_* come from corevx_cache.svh.
- One sub-module: corevx_lsu_align, combinational, inputs op/funct3/addr[1:0], outputs illegal, misaligned and cause.
- Watchdog counter and FSM live in the top module.

## Test plan

- LW at 0x1000, response DONE 3 cycles after issue with data 0xDEADBEEF → c_cmd LOAD for 1 cycle; l2e_done in cycle 3 with data 0xDEADBEEF; busy for 3 cycles.
- SH to 0x1001 with CHECK_ALIGN=1 → same-cycle done+exc, cause 6, c_cmd stays NONE; with CHECK_ALIGN=0 → STORE issued; MISSALIGNED response → cause 6.
- LB 0x2000 with PAGEFAULT response → cause 13; SW with ACCESSFAULT response → cause 7; FENCE with PAGEFAULT response → cause 15.
- WAIT_CYCLES=4, no response → done+exc cause 5 at cycle 4, state DRAIN. New valid ignored until DONE arrives, then the next request is accepted.
- Response and watchdog expiry in the same cycle → normal completion, no exception; c_reset_done=0 during a request → no issue until it rises.
- rst_n asserted while in WAIT → next cycle IDLE, all outputs 0; a stale DONE afterwards produces no l2e_done.
